// File: rtl/div_unit_pkg.sv
// div_unit_pkg: ALUCtrl encodings for the M-extension divide operations.
package div_unit_pkg;
  localparam logic [4:0] ALU_DIV  = 5'b01100;
  localparam logic [4:0] ALU_DIVU = 5'b01101;
  localparam logic [4:0] ALU_REM  = 5'b01110;
  localparam logic [4:0] ALU_REMU = 5'b01111;
endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one restoring-division iteration (shift, trial subtract, select).
module div_unit_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_n,
  output logic [XLEN-1:0] dvd_n
);
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;
  logic q_bit;
  // The extra top bit keeps divisors >= 2^(XLEN-1) exact.
  always_comb begin
    sh = {rem, dvd[XLEN-1]};
    diff = sh - {1'b0, dvs};
    q_bit = sh >= {1'b0, dvs};
    rem_n = q_bit ? diff[XLEN-1:0] : sh[XLEN-1:0];
    dvd_n = {dvd[XLEN-2:0], q_bit};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU, restoring radix-2, one bit per clock.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      ALUCtrl,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  state_t state;
  logic [XLEN-1:0] rem, dvd, dvs, rem_n, dvd_n, abs_a, abs_b;
  logic [CNT_W-1:0] cnt;
  logic is_rem, q_neg, r_neg, signed_op, rem_op, a_neg, b_neg;
  always_comb begin
    signed_op = ALUCtrl == ALU_DIV || ALUCtrl == ALU_REM;
    rem_op = ALUCtrl == ALU_REM || ALUCtrl == ALU_REMU;
    a_neg = signed_op & A[XLEN-1];
    b_neg = signed_op & B[XLEN-1];
    abs_a = a_neg ? -A : A;
    abs_b = b_neg ? -B : B;
  end
  div_unit_step #(.XLEN(XLEN)) u_step (
    .rem(rem),
    .dvd(dvd),
    .dvs(dvs),
    .rem_n(rem_n),
    .dvd_n(dvd_n)
  );
  // dvd doubles as the quotient: quotient bits shift in as dividend bits shift out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      is_rem <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          is_rem <= rem_op;
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          if (B == '0) begin
            result <= rem_op ? A : '1;
            state <= S_DONE;
          end else if (signed_op && A == MIN_INT && B == '1) begin
            result <= rem_op ? '0 : MIN_INT;
            state <= S_DONE;
          end else begin
            dvd <= abs_a;
            dvs <= abs_b;
            rem <= '0;
            cnt <= '0;
            busy <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rem <= rem_n;
          dvd <= dvd_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
        end
        S_FIX: begin
          result <= is_rem ? (r_neg ? -rem : rem) : (q_neg ? -dvd : dvd);
          busy <= 1'b0;
          state <= S_DONE;
        end
        default: begin
          done <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed hand-computed vectors.
module tb_div_unit;
  import div_unit_pkg::*;
  typedef struct {
    logic [31:0] res;
    int lat;
    int bc;
    int t0;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0] ALUCtrl = '0;
  logic busy, done;
  logic [31:0] result;
  exp_t sb[$];
  int cyc = 0;
  int n_done = 0;
  int busy_cnt = 0;
  int errors = 0;
  int checks = 0;
  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .ALUCtrl(ALUCtrl),
    .busy(busy),
    .done(done),
    .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(e.bc));
      end
      busy_cnt = 0;
    end
  end
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit push, input logic [31:0] res, input int lat, input int bc);
    exp_t e;
    @(negedge clk);
    ALUCtrl = op;
    A = a;
    B = b;
    start = 1'b1;
    if (push) begin
      e.res = res;
      e.lat = lat;
      e.bc = bc;
      e.t0 = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask
  task automatic wait_done(input string name);
    int n0 = n_done;
    for (int i = 0; i < 100 && n_done == n0; i++) begin
      @(negedge clk);
      #1;
    end
    if (n_done == n0) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask
  task automatic op(input string name, input logic [4:0] code, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] res, input bit fast);
    send(code, a, b, 1'b1, res, fast ? 1 : 34, fast ? 0 : 33);
    wait_done(name);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;
    op("div_neg_b", ALU_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0);
    op("rem_neg_b", ALU_REM, 32'd20, 32'hFFFFFFFD, 32'h00000002, 1'b0);
    op("divu_max", ALU_DIVU, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 1'b0);
    op("remu_max", ALU_REMU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b0);
    op("div_zero", ALU_DIV, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b1);
    op("remu_zero", ALU_REMU, 32'd7, 32'd0, 32'h00000007, 1'b1);
    op("div_ovf", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    op("rem_ovf", ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    op("rem_neg_a", ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0);
    op("div_neg_a", ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0);
    op("divu_big_b", ALU_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 1'b0);
    op("remu_big_b", ALU_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0);
    op("bad_code", 5'b00000, 32'd100, 32'd7, 32'd14, 1'b0);
    // A start mid-calculation must not disturb the running divide.
    send(ALU_DIVU, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h7FFFFFFF, 34, 33);
    repeat (4) @(negedge clk);
    ALUCtrl = ALU_DIV;
    A = 32'd100;
    B = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start");
    // Reset mid-calculation: outputs clear and no done follows.
    send(ALU_DIV, 32'd1000, 32'd9, 1'b0, 32'd0, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    op("after_reset", ALU_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
